// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg -- shared definitions for the seq_gen serializer.
//   state_e         : one-hot FSM state encoding (S_IDLE, S_SHIFT, S_GAP)
//   DEFAULT_PATTERN : default 4-bit pattern tracked by the reference counter
package seq_gen_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_GAP   = 3'b100
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_ref_counter.sv
// seq_ref_counter -- counts (overlapping) occurrences of PATTERN in a serial
// bit stream. Keeps the last three valid bits as history; history and count
// persist across words and idle time until clr_i.
// Ports:
//   clk_i       : clock, rising edge
//   clr_i       : synchronous active-high clear (history and count)
//   valid_i     : bit_i is a stream bit this cycle
//   bit_i       : serial stream bit
//   match_cnt_o : saturating (255) count of PATTERN occurrences
module seq_ref_counter
  import seq_gen_pkg::*;
#(
  parameter logic [3:0] PATTERN = DEFAULT_PATTERN
) (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       valid_i,
  input  logic       bit_i,
  output logic [7:0] match_cnt_o
);

  logic [2:0] hist_q, hist_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (valid_i) begin
      hist_d = {hist_q[1:0], bit_i};
      // Oldest history bit lines up with PATTERN[3], current bit with PATTERN[0].
      if (({hist_q, bit_i} == PATTERN) && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_cnt_o = cnt_q;

endmodule

// File: rtl/seq_gen.sv
// seq_gen -- parallel-to-serial word generator, MSB first, with optional
// inter-word gap and an optional pattern reference counter.
// Build option: define SEQ_GEN_REFCNT_EN to build the pattern counter
// (seq_ref_counter); otherwise match_cnt_o is tied to 0.
// Ports:
//   clk_i       : clock, rising edge
//   clr_i       : synchronous active-high reset
//   data_i      : parallel word to serialize
//   load_i      : word offer, taken when load_i && ready_o
//   hold_i      : downstream pause, freezes shifting
//   ready_o     : a word can be accepted this cycle
//   input_o     : serial bit (MSB first)
//   valid_o     : input_o is a stream bit this cycle
//   last_o      : current valid bit is bit 0 of the word
//   match_cnt_o : count of PATTERN occurrences in the emitted stream
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter int         GAP_CYCLES = 0,
  parameter logic [3:0] PATTERN    = DEFAULT_PATTERN
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             load_i,
  input  logic             hold_i,
  output logic             ready_o,
  output logic             input_o,
  output logic             valid_o,
  output logic             last_o,
  output logic [7:0]       match_cnt_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  // Gap counter runs GAP_CYCLES-1 .. 0, one S_GAP cycle per value.
  localparam logic [2:0] GAP_LOAD = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gap_q, gap_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    last_o  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_o = 1'b1;
        if (load_i) begin
          shift_d = data_i;
          cnt_d   = CNT_LOAD;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        valid_o = !hold_i;
        // A held cycle changes nothing, including on the last bit.
        if (!hold_i) begin
          if (cnt_q != '0) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - CNT_W'(1);
          end else begin
            last_o = 1'b1;
            if (GAP_CYCLES == 0) begin
              // Ready on the last bit so a new word follows without a bubble.
              ready_o = 1'b1;
              if (load_i) begin
                shift_d = data_i;
                cnt_d   = CNT_LOAD;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              gap_d   = GAP_LOAD;
              state_d = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        if (gap_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 3'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  // Serial output only reflects the register while a word is in flight.
  assign input_o = (state_q == S_SHIFT) && shift_q[WIDTH-1];

`ifdef SEQ_GEN_REFCNT_EN
  seq_ref_counter #(
    .PATTERN(PATTERN)
  ) u_ref_counter (
    .clk_i      (clk_i),
    .clr_i      (clr_i),
    .valid_i    (valid_o),
    .bit_i      (input_o),
    .match_cnt_o(match_cnt_o)
  );
`else
  // No counter built; PATTERN only matters when it is, so it is masked away.
  assign match_cnt_o = 8'(PATTERN) & 8'h00;
`endif

endmodule

// File: tb/tb_seq_gen.sv
module tb_seq_gen;

  localparam int W = 8;
`ifdef SEQ_GEN_REFCNT_EN
  localparam bit REF_ON = 1'b1;
`else
  localparam bit REF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: GAP_CYCLES=0, dut2: GAP_CYCLES=2
  logic         clr0 = 1'b1, load0 = 1'b0, hold0 = 1'b0;
  logic [W-1:0] data0 = '0;
  logic         ready0, in0, valid0, last0;
  logic [7:0]   mc0;

  logic         clr2 = 1'b1, load2 = 1'b0, hold2 = 1'b0;
  logic [W-1:0] data2 = '0;
  logic         ready2, in2, valid2, last2;
  logic [7:0]   mc2;

  seq_gen #(.WIDTH(W), .GAP_CYCLES(0), .PATTERN(4'b1011)) dut0 (
    .clk_i(clk), .clr_i(clr0), .data_i(data0), .load_i(load0), .hold_i(hold0),
    .ready_o(ready0), .input_o(in0), .valid_o(valid0), .last_o(last0),
    .match_cnt_o(mc0)
  );

  seq_gen #(.WIDTH(W), .GAP_CYCLES(2), .PATTERN(4'b1011)) dut2 (
    .clk_i(clk), .clr_i(clr2), .data_i(data2), .load_i(load2), .hold_i(hold2),
    .ready_o(ready2), .input_o(in2), .valid_o(valid2), .last_o(last2),
    .match_cnt_o(mc2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int emc(input int n);
    if (!REF_ON) return 0;
    return (n > 255) ? 255 : n;
  endfunction

  typedef struct {
    logic       clr, load, hold;
    logic [7:0] data;
    logic       ready, valid, bit_o, last;
    logic       chk_mc;
    logic [7:0] mc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic clr, input logic load, input logic hold,
                               input logic [7:0] data, input logic ready,
                               input logic valid, input logic bit_o, input logic last,
                               input logic chk_mc, input int mc);
    vec_t v;
    v.clr = clr; v.load = load; v.hold = hold; v.data = data;
    v.ready = ready; v.valid = valid; v.bit_o = bit_o; v.last = last;
    v.chk_mc = chk_mc; v.mc = 8'(mc);
    return v;
  endfunction

  // Eight valid cycles of word w; optionally offer the next word on the last bit.
  task automatic add_word(input logic [7:0] w, input logic load_on_last, input logic [7:0] nxt);
    for (int i = W - 1; i >= 0; i--) begin
      tbl.push_back(mkv(1'b0, (i == 0) && load_on_last, 1'b0, (i == 0) ? nxt : 8'h00,
                        i == 0, 1'b1, w[i], i == 0, 1'b0, 0));
    end
  endtask

  task automatic reset0();
    load0 = 1'b0; hold0 = 1'b0;
    @(negedge clk); clr0 = 1'b1;
    @(negedge clk); clr0 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- table-driven: 8'hB6, then B0/0B back-to-back
    tbl.push_back(mkv(0, 1, 0, 8'hB6, 1, 0, 0, 0, 1, 0));
    add_word(8'hB6, 1'b0, 8'h00);
    tbl.push_back(mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, emc(2)));
    tbl.push_back(mkv(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 1, 0, 8'hB0, 1, 0, 0, 0, 1, 0));
    add_word(8'hB0, 1'b1, 8'h0B);
    add_word(8'h0B, 1'b0, 8'h00);
    tbl.push_back(mkv(0, 0, 0, 8'h00, 1, 0, 0, 0, 1, emc(2)));

    reset0();
    foreach (tbl[i]) begin
      @(negedge clk);
      clr0 = tbl[i].clr; load0 = tbl[i].load; hold0 = tbl[i].hold; data0 = tbl[i].data;
      #1;
      chk($sformatf("tbl[%0d].ready", i), ready0, tbl[i].ready);
      chk($sformatf("tbl[%0d].valid", i), valid0, tbl[i].valid);
      chk($sformatf("tbl[%0d].input", i), in0, tbl[i].bit_o);
      chk($sformatf("tbl[%0d].last", i), last0, tbl[i].last);
      if (tbl[i].chk_mc) chk($sformatf("tbl[%0d].match_cnt", i), mc0, tbl[i].mc);
    end
    $display("table: %0d vectors applied", tbl.size());

    // ---------------- hold for 3 cycles after the 2nd bit of 8'hFF
    begin
      int cyc = 0;
      bit done = 0;
      reset0();
      load0 = 1'b1; data0 = 8'hFF; #1;
      chk("hold.accept_ready", ready0, 1);
      @(negedge clk); load0 = 1'b0;
      for (int i = 0; i < 2; i++) begin
        #1; cyc++; chk("hold.pre_valid", valid0, 1); @(negedge clk);
      end
      hold0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
        #1; cyc++;
        chk("hold.valid_low", valid0, 0);
        chk("hold.input_frozen", in0, 1);
        chk("hold.ready_low", ready0, 0);
        @(negedge clk);
      end
      hold0 = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
        #1; cyc++;
        if (last0) done = 1;
        @(negedge clk);
      end
      chk("hold.done", done, 1);
      chk("hold.word_cycles", cyc, 11);
      $display("hold: word completed after %0d cycles", cyc);
    end

    // ---------------- clr after the 3rd bit
    reset0();
    load0 = 1'b1; data0 = 8'hB6; #1;
    @(negedge clk); load0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("clr.pre_valid", valid0, 1); @(negedge clk);
    end
    clr0 = 1'b1; load0 = 1'b1; hold0 = 1'b1; #1;
    @(negedge clk); clr0 = 1'b0; load0 = 1'b0; hold0 = 1'b0; #1;
    chk("clr.valid", valid0, 0);
    chk("clr.ready", ready0, 1);
    chk("clr.input", in0, 0);
    chk("clr.match_cnt", mc0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1; chk("clr.no_more_valid", valid0, 0);
    end
    $display("clr: mid-word reset applied");

    // ---------------- GAP_CYCLES=2 with load offered every cycle
    begin
      int lasts = 0;
      int gapc = 0;
      bit counting = 0;
      @(negedge clk); clr2 = 1'b1;
      @(negedge clk); clr2 = 1'b0; load2 = 1'b1; data2 = 8'hA5;
      for (int c = 0; c < 60 && lasts < 3; c++) begin
        #1;
        if (counting) begin
          if (valid2) begin
            chk("gap.len", gapc, 2);
            counting = 0;
          end else if (!ready2) begin
            gapc++;
          end
        end
        if (last2) begin
          lasts++; counting = 1; gapc = 0;
        end
        @(negedge clk);
      end
      load2 = 1'b0;
      chk("gap.words", lasts, 3);
      $display("gap: %0d words observed", lasts);
    end

    // ---------------- 300 words of 8'hBB, saturation
    begin
      int accepted = 0;
      int lasts = 0;
      reset0();
      for (int c = 0; c < 3000 && lasts < 300; c++) begin
        load0 = (accepted < 300); data0 = 8'hBB;
        #1;
        if (ready0 && load0) accepted++;
        if (last0) begin
          lasts++;
          if (lasts == 10) chk("sat.mc_word10", mc0, emc(19));
        end
        @(negedge clk);
      end
      load0 = 1'b0; #1;
      chk("sat.words", lasts, 300);
      chk("sat.match_cnt", mc0, emc(600));
      chk("sat.idle_valid", valid0, 0);
      $display("sat: %0d words, match_cnt=%0d", lasts, mc0);
    end

    // ---------------- randomized against a queue-based reference model
    begin
      bit q[$];
      int hist = 0;
      int mcount = 0;
      int win;
      bit busy, ev, ein, elast, erdy;
      reset0();
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        clr0  = ($urandom_range(0, 149) == 0);
        load0 = $urandom_range(0, 1) == 1;
        hold0 = ($urandom_range(0, 3) == 0);
        data0 = 8'($urandom);
        #1;
        busy  = (q.size() > 0);
        ev    = busy && !hold0;
        ein   = busy ? q[0] : 1'b0;
        elast = ev && (q.size() == 1);
        erdy  = !busy || elast;
        chk("rand.valid", valid0, ev);
        chk("rand.input", in0, ein);
        chk("rand.last", last0, elast);
        chk("rand.ready", ready0, erdy);
        chk("rand.match_cnt", mc0, emc(mcount));
        @(posedge clk);
        if (clr0) begin
          q.delete(); hist = 0; mcount = 0;
        end else begin
          if (ev) begin
            win = (hist * 2 + int'(q.pop_front())) % 16;
            if (win == 11) mcount++;
            hist = win % 8;
          end
          if (erdy && load0) begin
            for (int k = W - 1; k >= 0; k--) q.push_back(data0[k]);
          end
        end
      end
      $display("rand: 3000 cycles, model match count %0d", mcount);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
